heichips_qspi_arb: RTL and testbench

HEICHIPS_QSPI_ARB -- requirements
Module: heichips_qspi_arb

---
 rtl/heichips_qspi_arb_pkg.sv | 20 ++
 rtl/heichips_sync.sv | 25 ++
 rtl/heichips_qspi_arb.sv | 139 +++++++++++++
 tb/tb_heichips_qspi_arb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/heichips_qspi_arb_pkg.sv
// rtl/heichips_qspi_arb_pkg.sv - shared types and constants for the QSPI bus arbiter
package heichips_qspi_arb_pkg;

  // Bus ownership states: core owns, core draining, programmer owns, programmer draining
  typedef enum logic [1:0] {
    ST_CORE = 2'd0,
    ST_C2P  = 2'd1,
    ST_PRG  = 2'd2,
    ST_P2C  = 2'd3
  } arb_state_t;

  localparam int GUARD_CYCLES_DEFAULT = 4;

  // Values driven onto the shared pins when nobody owns the bus
  localparam logic       IDLE_CS_N  = 1'b1;
  localparam logic       IDLE_SCK   = 1'b0;
  localparam logic [3:0] IDLE_SDO   = 4'b0000;
  localparam logic [3:0] IDLE_SDOEN = 4'b0000;

endpackage

// File: rtl/heichips_sync.sv
// rtl/heichips_sync.sv - single-bit multi-flop synchronizer with reset value
module heichips_sync #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] ff;

  // Shift the asynchronous input through DEPTH flops; reset loads the idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= {DEPTH{RST_VAL}};
    end else begin
      ff <= {ff[DEPTH-2:0], din};
    end
  end

  assign dout = ff[DEPTH-1];

endmodule

// File: rtl/heichips_qspi_arb.sv
// rtl/heichips_qspi_arb.sv - arbitrates the shared QSPI pins between core and external programmer
module heichips_qspi_arb
  import heichips_qspi_arb_pkg::*;
#(
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       prg_req_i,
  input  logic       prg_cs_n_i,
  input  logic       prg_sck_i,
  input  logic       prg_copi_i,
  output logic       prg_cipo_o,
  output logic       prg_gnt_o,
  output logic       core_hold_o,
  input  logic       core_cs_rom_n_i,
  input  logic       core_cs_ram_n_i,
  input  logic       core_sck_i,
  input  logic [3:0] core_sdo_i,
  input  logic [3:0] core_sdoen_i,
  output logic [3:0] core_sdi_o,
  output logic       qspi_cs_rom_n_o,
  output logic       qspi_cs_ram_n_o,
  output logic       qspi_sck_o,
  output logic [3:0] qspi_sdo_o,
  output logic [3:0] qspi_sdoen_o,
  input  logic [3:0] qspi_sdi_i
);

  localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

  logic       prg_req_s;
  logic       prg_cs_s;
  logic       core_busy;
  arb_state_t state;
  logic [7:0] gcnt;

  // Only request and chip select steer the FSM; clock and data go straight to the pins
  heichips_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_req (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  (prg_req_i),
    .dout (prg_req_s)
  );

  heichips_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  (prg_cs_n_i),
    .dout (prg_cs_s)
  );

  assign core_busy = !core_cs_rom_n_i || !core_cs_ram_n_i;

  // Ownership FSM: a handover only completes after GUARD_CYCLES consecutive idle-bus cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_P2C;
      gcnt  <= '0;
    end else begin
      case (state)
        ST_CORE: begin
          if (prg_req_s) begin
            state <= ST_C2P;
            gcnt  <= '0;
          end
        end
        ST_C2P: begin
          if (!prg_req_s) begin
            state <= ST_CORE;
            gcnt  <= '0;
          end else if (core_busy) begin
            gcnt <= '0;
          end else if (gcnt == GUARD_LAST) begin
            state <= ST_PRG;
            gcnt  <= '0;
          end else begin
            gcnt <= gcnt + 8'd1;
          end
        end
        ST_PRG: begin
          if (!prg_req_s) begin
            state <= ST_P2C;
            gcnt  <= '0;
          end
        end
        ST_P2C: begin
          // A fresh request cannot cut the drain short; the bus always returns to the core first
          if (!prg_cs_s) begin
            gcnt <= '0;
          end else if (gcnt == GUARD_LAST) begin
            state <= ST_CORE;
            gcnt  <= '0;
          end else begin
            gcnt <= gcnt + 8'd1;
          end
        end
        default: begin
          state <= ST_P2C;
          gcnt  <= '0;
        end
      endcase
    end
  end

  assign prg_gnt_o   = (state == ST_PRG);
  assign core_hold_o = (state != ST_CORE);
  assign prg_cipo_o  = qspi_sdi_i[1];

  // Pin mux selected purely by the registered state
  always_comb begin
    qspi_cs_rom_n_o = IDLE_CS_N;
    qspi_cs_ram_n_o = IDLE_CS_N;
    qspi_sck_o      = IDLE_SCK;
    qspi_sdo_o      = IDLE_SDO;
    qspi_sdoen_o    = IDLE_SDOEN;
    core_sdi_o      = 4'b0000;
    case (state)
      ST_CORE, ST_C2P: begin
        qspi_cs_rom_n_o = core_cs_rom_n_i;
        qspi_cs_ram_n_o = core_cs_ram_n_i;
        qspi_sck_o      = core_sck_i;
        qspi_sdo_o      = core_sdo_i;
        qspi_sdoen_o    = core_sdoen_i;
        core_sdi_o      = qspi_sdi_i;
      end
      ST_PRG: begin
        qspi_cs_rom_n_o = prg_cs_n_i;
        qspi_sck_o      = prg_sck_i;
        qspi_sdo_o      = {3'b000, prg_copi_i};
        qspi_sdoen_o    = 4'b0001;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_heichips_qspi_arb.sv
// tb/tb_heichips_qspi_arb.sv - directed self-checking bench for the QSPI arbiter
module tb_heichips_qspi_arb;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       prg_req_i, prg_cs_n_i, prg_sck_i, prg_copi_i;
  logic       prg_cipo_o, prg_gnt_o, core_hold_o;
  logic       core_cs_rom_n_i, core_cs_ram_n_i, core_sck_i;
  logic [3:0] core_sdo_i, core_sdoen_i, core_sdi_o;
  logic       qspi_cs_rom_n_o, qspi_cs_ram_n_o, qspi_sck_o;
  logic [3:0] qspi_sdo_o, qspi_sdoen_o, qspi_sdi_i;

  int vectors = 0;
  int miscompares = 0;

  heichips_qspi_arb dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .prg_req_i       (prg_req_i),
    .prg_cs_n_i      (prg_cs_n_i),
    .prg_sck_i       (prg_sck_i),
    .prg_copi_i      (prg_copi_i),
    .prg_cipo_o      (prg_cipo_o),
    .prg_gnt_o       (prg_gnt_o),
    .core_hold_o     (core_hold_o),
    .core_cs_rom_n_i (core_cs_rom_n_i),
    .core_cs_ram_n_i (core_cs_ram_n_i),
    .core_sck_i      (core_sck_i),
    .core_sdo_i      (core_sdo_i),
    .core_sdoen_i    (core_sdoen_i),
    .core_sdi_o      (core_sdi_o),
    .qspi_cs_rom_n_o (qspi_cs_rom_n_o),
    .qspi_cs_ram_n_o (qspi_cs_ram_n_o),
    .qspi_sck_o      (qspi_sck_o),
    .qspi_sdo_o      (qspi_sdo_o),
    .qspi_sdoen_o    (qspi_sdoen_o),
    .qspi_sdi_i      (qspi_sdi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle_bus(input string tag);
    check_vec({tag, "_cs_rom"}, 8'(qspi_cs_rom_n_o), 8'd1);
    check_vec({tag, "_cs_ram"}, 8'(qspi_cs_ram_n_o), 8'd1);
    check_vec({tag, "_sck"}, 8'(qspi_sck_o), 8'd0);
    check_vec({tag, "_sdo"}, 8'(qspi_sdo_o), 8'd0);
    check_vec({tag, "_sdoen"}, 8'(qspi_sdoen_o), 8'd0);
    check_vec({tag, "_core_sdi"}, 8'(core_sdi_o), 8'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    prg_req_i = 1'b0; prg_cs_n_i = 1'b1; prg_sck_i = 1'b0; prg_copi_i = 1'b0;
    core_cs_rom_n_i = 1'b1; core_cs_ram_n_i = 1'b1; core_sck_i = 1'b1;
    core_sdo_i = 4'hF; core_sdoen_i = 4'hF; qspi_sdi_i = 4'hF;

    // Reset: bus idle even with the core driving everything
    step(3);
    check_idle_bus("rst");
    check_vec("rst_hold", 8'(core_hold_o), 8'd1);
    check_vec("rst_gnt", 8'(prg_gnt_o), 8'd0);

    // Release: four guard edges, then core ownership
    core_sck_i = 1'b0; core_sdo_i = 4'h0; core_sdoen_i = 4'h0;
    rst_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check_vec($sformatf("rel_hold_%0d", i), 8'(core_hold_o), (i < 4) ? 8'd1 : 8'd0);
    end
    core_cs_rom_n_i = 1'b0; core_sck_i = 1'b1; core_sdo_i = 4'hA; core_sdoen_i = 4'hC;
    qspi_sdi_i = 4'h5; #1;
    check_vec("core_cs_rom", 8'(qspi_cs_rom_n_o), 8'd0);
    check_vec("core_cs_ram", 8'(qspi_cs_ram_n_o), 8'd1);
    check_vec("core_sck", 8'(qspi_sck_o), 8'd1);
    check_vec("core_sdo", 8'(qspi_sdo_o), 8'hA);
    check_vec("core_sdoen", 8'(qspi_sdoen_o), 8'hC);
    check_vec("core_sdi", 8'(core_sdi_o), 8'h5);
    check_vec("core_cipo0", 8'(prg_cipo_o), 8'd0);
    qspi_sdi_i = 4'h2; #1;
    check_vec("core_cipo1", 8'(prg_cipo_o), 8'd1);
    core_cs_rom_n_i = 1'b1; core_sck_i = 1'b0; core_sdo_i = 4'h0; core_sdoen_i = 4'h0;

    // Core idle, programmer requests: grant on the 7th edge
    prg_req_i = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      check_vec($sformatf("req_gnt_%0d", i), 8'(prg_gnt_o), (i == 7) ? 8'd1 : 8'd0);
      check_vec($sformatf("req_hold_%0d", i), 8'(core_hold_o), (i >= 3) ? 8'd1 : 8'd0);
    end
    prg_sck_i = 1'b1; prg_copi_i = 1'b1; qspi_sdi_i = 4'hF; #1;
    check_vec("prg_sck1", 8'(qspi_sck_o), 8'd1);
    check_vec("prg_sdoen", 8'(qspi_sdoen_o), 8'h1);
    check_vec("prg_sdo", 8'(qspi_sdo_o), 8'h1);
    check_vec("prg_cs_ram", 8'(qspi_cs_ram_n_o), 8'd1);
    check_vec("prg_core_sdi", 8'(core_sdi_o), 8'h0);
    check_vec("prg_cipo", 8'(prg_cipo_o), 8'd1);
    prg_sck_i = 1'b0; #1;
    check_vec("prg_sck0", 8'(qspi_sck_o), 8'd0);

    // Programmer mid-transaction drops request: drain holds while its CS is low
    prg_cs_n_i = 1'b0; #1;
    check_vec("prg_cs_rom", 8'(qspi_cs_rom_n_o), 8'd0);
    step(3);
    prg_req_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check_vec($sformatf("drop_gnt_%0d", i), 8'(prg_gnt_o), (i < 3) ? 8'd1 : 8'd0);
    end
    check_idle_bus("p2c");
    step(6);
    check_vec("p2c_stuck_hold", 8'(core_hold_o), 8'd1);
    prg_cs_n_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      check_vec($sformatf("p2c_hold_%0d", i), 8'(core_hold_o), (i < 6) ? 8'd1 : 8'd0);
    end

    // Request while the core is busy: passthrough continues until CS released + guard
    core_cs_rom_n_i = 1'b0; core_sdoen_i = 4'hF;
    prg_req_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      check_vec($sformatf("busy_gnt_%0d", i), 8'(prg_gnt_o), 8'd0);
      check_vec($sformatf("busy_cs_%0d", i), 8'(qspi_cs_rom_n_o), 8'd0);
    end
    check_vec("busy_hold", 8'(core_hold_o), 8'd1);
    check_vec("busy_sdoen", 8'(qspi_sdoen_o), 8'hF);
    core_cs_rom_n_i = 1'b1; core_sdoen_i = 4'h0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check_vec($sformatf("busy_rel_gnt_%0d", i), 8'(prg_gnt_o), (i == 4) ? 8'd1 : 8'd0);
    end
    prg_req_i = 1'b0;
    step(7);
    check_vec("busy_back_hold", 8'(core_hold_o), 8'd0);

    // One-cycle request pulse: brief C2P, straight back to CORE, no grant
    prg_req_i = 1'b1;
    step(1);
    check_vec("pulse_gnt_1", 8'(prg_gnt_o), 8'd0);
    prg_req_i = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      step(1);
      check_vec($sformatf("pulse_gnt_%0d", i), 8'(prg_gnt_o), 8'd0);
      check_vec($sformatf("pulse_hold_%0d", i), 8'(core_hold_o), (i == 3) ? 8'd1 : 8'd0);
    end

    // Reset in PRG with programmer CS low: idle bus on the very next edge
    prg_req_i = 1'b1;
    step(7);
    check_vec("rst2_gnt_pre", 8'(prg_gnt_o), 8'd1);
    prg_cs_n_i = 1'b0; #1;
    check_vec("rst2_cs_pre", 8'(qspi_cs_rom_n_o), 8'd0);
    rst_i = 1'b1;
    step(1);
    check_idle_bus("rst2");
    check_vec("rst2_gnt", 8'(prg_gnt_o), 8'd0);
    check_vec("rst2_hold", 8'(core_hold_o), 8'd1);
    rst_i = 1'b0; prg_req_i = 1'b0; prg_cs_n_i = 1'b1;
    step(3);
    check_vec("rst2_rel_hold3", 8'(core_hold_o), 8'd1);
    step(1);
    check_vec("rst2_rel_hold4", 8'(core_hold_o), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
